mor1kx_cfgrs_spr_port: RTL and testbench
========================================

MOR1KX_CFGRS_SPR_PORT -- requirements
Module: mor1kx_cfgrs_spr_port

Interface
REQ-001 Parameter OPTION_RSP_DELAY, default 0, extra wait cycles (0..3) inserted between lookup and ack.
REQ-002 Parameter OPTION_WE_ERR_EN, default 1, enables write-attempt error reporting.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset (fixed by design decision).
REQ-005 Port spr_bus_stb_i, input, 1, SPR access request strobe, held high until ack.
REQ-006 Port spr_bus_we_i, input, 1, 1 = write access, 0 = read access.
REQ-007 Port spr_bus_addr_i, input, 16, SPR address as {group[15:11], index[10:0]}.
REQ-008 Port spr_bus_dat_i, input, 32, write data; ignored, since all served registers are read-only.
REQ-009 Ports spr_vr, spr_vr2, spr_upr, spr_cpucfgr, spr_dmmucfgr, spr_immucfgr, spr_dccfgr, spr_iccfgr, spr_dcfgr, spr_pccfgr, spr_fpcsr, spr_avr, input, 32 each, configuration register values.
REQ-010 Port spr_bus_ack_o, output, 1, single-cycle completion pulse.
REQ-011 Port spr_bus_dat_o, output, 32, read data; valid only in the ack cycle.
REQ-012 Port spr_bus_hit_o, output, 1, registered; high in the ack cycle when the address decodes to a served register.
REQ-013 Port we_err_o, output, 1, sticky flag: a write hit a served register.
REQ-014 Port we_err_cnt_o, output, 8, saturating count of write attempts to served registers.

Function
REQ-015 Served map (group 0): 0x000 VR, 0x001 UPR, 0x002 CPUCFGR, 0x003 DMMUCFGR, 0x004 IMMUCFGR, 0x005 DCCFGR, 0x006 ICCFGR, 0x007 DCFGR, 0x008 PCCFGR, 0x009 VR2, 0x00A AVR, 0x014 FPCSR; any other address is a miss.
REQ-016 FSM states: IDLE, LOOKUP, DELAY, ACK, DONE.
REQ-017 IDLE -> LOOKUP when stb=1; address and we are captured in that cycle.
REQ-018 LOOKUP: decode the captured address and register the selected value into a data holding register.
REQ-019 LOOKUP -> DELAY if OPTION_RSP_DELAY>0, else -> ACK.
REQ-020 DELAY: count down OPTION_RSP_DELAY cycles, then -> ACK.
REQ-021 ACK: ack_o=1 for exactly one cycle, with dat_o = held value and hit_o = decode result; then -> DONE.
REQ-022 DONE: remain until stb=0, then -> IDLE; no new access is accepted while stb stays high after ack.
REQ-023 Latency from the stb rising cycle to ack: 2+OPTION_RSP_DELAY cycles.
REQ-024 Miss, or write: dat_o = 0 in the ack cycle; a write still acks (no bus hang).
REQ-025 dat_o = 0 in every non-ack cycle.
REQ-026 Data is a snapshot taken in LOOKUP; input changes afterwards do not alter the ack data.
REQ-027 Write with hit and OPTION_WE_ERR_EN=1: we_err_o is set and we_err_cnt_o increments in the ack cycle; the count saturates at 0xFF.
REQ-028 Write with miss: no error update.
REQ-029 OPTION_WE_ERR_EN=0: we_err_o and we_err_cnt_o are constant 0.
REQ-030 stb dropped before ack: the FSM completes to ACK and pulses ack anyway, then DONE sees stb=0 and returns to IDLE.

Reset
REQ-031 rst=1 asynchronously forces IDLE, ack_o=0, dat_o=0, hit_o=0, we_err_o=0, we_err_cnt_o=0, held data=0, delay counter=0.
REQ-032 Reset asserted mid-access aborts the access: no ack is issued, and after release the FSM starts in IDLE.
REQ-033 The first access is accepted in the first clock edge after rst deasserts.

Verification
REQ-034 Delay=0, read addr 0x0000 with spr_vr=0x10000040 -> ack on cycle 2, dat_o=0x10000040, hit_o=1.
REQ-035 Delay=3, read 0x0014 with spr_fpcsr=0 -> ack on cycle 5, dat_o=0, hit_o=1; changing inputs after LOOKUP does not affect dat_o.
REQ-036 Read 0x000B and read 0x0801 (group 1) -> ack, dat_o=0, hit_o=0, error flag and count unchanged.
REQ-037 260 writes to 0x0002 -> 260 acks, we_err_o=1, we_err_cnt_o=0xFF; write to 0x00FF -> count unchanged.
REQ-038 stb held high for 10 cycles after ack -> exactly one ack; a second access is accepted only after stb=0.
REQ-039 rst pulsed during LOOKUP -> no ack, outputs 0; the next read of 0x0009 returns spr_vr2 with normal latency.

Source files
------------

// File: rtl/mor1kx_cfgrs_spr_port.sv
// Read-only SPR port serving the group-0 configuration registers.
// One access at a time: IDLE -> LOOKUP -> [DELAY] -> ACK -> DONE.
module mor1kx_cfgrs_spr_port #(
  parameter int OPTION_RSP_DELAY = 0,
  parameter bit OPTION_WE_ERR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spr_bus_stb_i,
  input  logic        spr_bus_we_i,
  input  logic [15:0] spr_bus_addr_i,
  input  logic [31:0] spr_bus_dat_i,
  input  logic [31:0] spr_vr,
  input  logic [31:0] spr_vr2,
  input  logic [31:0] spr_upr,
  input  logic [31:0] spr_cpucfgr,
  input  logic [31:0] spr_dmmucfgr,
  input  logic [31:0] spr_immucfgr,
  input  logic [31:0] spr_dccfgr,
  input  logic [31:0] spr_iccfgr,
  input  logic [31:0] spr_dcfgr,
  input  logic [31:0] spr_pccfgr,
  input  logic [31:0] spr_fpcsr,
  input  logic [31:0] spr_avr,
  output logic        spr_bus_ack_o,
  output logic [31:0] spr_bus_dat_o,
  output logic        spr_bus_hit_o,
  output logic        we_err_o,
  output logic [7:0]  we_err_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_DELAY,
    S_ACK,
    S_DONE
  } state_t;

  // DELAY lasts OPTION_RSP_DELAY cycles, so the counter is loaded with one less.
  localparam logic [1:0] DLY_INIT = (OPTION_RSP_DELAY > 0) ? 2'(OPTION_RSP_DELAY - 1) : 2'd0;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_addr;
  logic        r_we;
  logic [31:0] r_dat;
  logic        r_hit;
  logic [1:0]  r_dly;
  logic        r_err;
  logic [7:0]  r_cnt;
  logic [31:0] w_dec_dat;
  logic        w_dec_hit;
  logic        w_ack;
  logic        w_unused_dat;

  // Write data is never stored: every served register is read-only.
  assign w_unused_dat = ^spr_bus_dat_i;

  always_comb begin
    w_dec_hit = 1'b1;
    w_dec_dat = '0;
    if (r_addr[15:11] != 5'd0) begin
      w_dec_hit = 1'b0;
    end else begin
      case (r_addr[10:0])
        11'h000: w_dec_dat = spr_vr;
        11'h001: w_dec_dat = spr_upr;
        11'h002: w_dec_dat = spr_cpucfgr;
        11'h003: w_dec_dat = spr_dmmucfgr;
        11'h004: w_dec_dat = spr_immucfgr;
        11'h005: w_dec_dat = spr_dccfgr;
        11'h006: w_dec_dat = spr_iccfgr;
        11'h007: w_dec_dat = spr_dcfgr;
        11'h008: w_dec_dat = spr_pccfgr;
        11'h009: w_dec_dat = spr_vr2;
        11'h00A: w_dec_dat = spr_avr;
        11'h014: w_dec_dat = spr_fpcsr;
        default: w_dec_hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (spr_bus_stb_i) w_next = S_LOOKUP;
      S_LOOKUP: w_next = (OPTION_RSP_DELAY > 0) ? S_DELAY : S_ACK;
      S_DELAY:  if (r_dly == 2'd0) w_next = S_ACK;
      S_ACK:    w_next = S_DONE;
      S_DONE:   if (!spr_bus_stb_i) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_dat   <= '0;
      r_hit   <= 1'b0;
      r_dly   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && spr_bus_stb_i) begin
        r_addr <= spr_bus_addr_i;
        r_we   <= spr_bus_we_i;
      end
      // Snapshot: later input changes cannot alter the acked data.
      if (r_state == S_LOOKUP) begin
        r_hit <= w_dec_hit;
        r_dat <= (w_dec_hit && !r_we) ? w_dec_dat : 32'd0;
        r_dly <= DLY_INIT;
      end
      if (r_state == S_DELAY && r_dly != 2'd0) r_dly <= r_dly - 2'd1;
      if (OPTION_WE_ERR_EN && r_state == S_ACK && r_we && r_hit) begin
        r_err <= 1'b1;
        if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign w_ack         = (r_state == S_ACK);
  assign spr_bus_ack_o = w_ack;
  assign spr_bus_dat_o = w_ack ? r_dat : 32'd0;
  assign spr_bus_hit_o = w_ack & r_hit;
  assign we_err_o      = r_err;
  assign we_err_cnt_o  = r_cnt;

endmodule

// File: tb/tb_mor1kx_cfgrs_spr_port.sv
// Directed bench: delay-0, delay-3 and error-disabled instances share one stimulus bus.
module tb_mor1kx_cfgrs_spr_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, we;
  logic [15:0] addr;
  logic [31:0] wdat;
  logic [31:0] vr, vr2, upr, cpucfgr, dmmu, immu, dccfgr, iccfgr, dcfgr, pccfgr, fpcsr, avr;

  logic        ack0, hit0, err0, ack3, hit3, err3, ackn, hitn, errn;
  logic [31:0] dato0, dato3, daton;
  logic [7:0]  cnt0, cnt3, cntn;

  int n_chk = 0;
  int n_err = 0;

  int          lat0, lat3, acks0, acks3;
  logic [31:0] dat0, dat3;
  logic        h0, h3;
  bit          mutate;

  always #5 clk = ~clk;

  mor1kx_cfgrs_spr_port #(.OPTION_RSP_DELAY(0), .OPTION_WE_ERR_EN(1'b1)) u_d0 (
    .clk(clk), .rst(rst), .spr_bus_stb_i(stb), .spr_bus_we_i(we), .spr_bus_addr_i(addr),
    .spr_bus_dat_i(wdat), .spr_vr(vr), .spr_vr2(vr2), .spr_upr(upr), .spr_cpucfgr(cpucfgr),
    .spr_dmmucfgr(dmmu), .spr_immucfgr(immu), .spr_dccfgr(dccfgr), .spr_iccfgr(iccfgr),
    .spr_dcfgr(dcfgr), .spr_pccfgr(pccfgr), .spr_fpcsr(fpcsr), .spr_avr(avr),
    .spr_bus_ack_o(ack0), .spr_bus_dat_o(dato0), .spr_bus_hit_o(hit0),
    .we_err_o(err0), .we_err_cnt_o(cnt0));

  mor1kx_cfgrs_spr_port #(.OPTION_RSP_DELAY(3), .OPTION_WE_ERR_EN(1'b1)) u_d3 (
    .clk(clk), .rst(rst), .spr_bus_stb_i(stb), .spr_bus_we_i(we), .spr_bus_addr_i(addr),
    .spr_bus_dat_i(wdat), .spr_vr(vr), .spr_vr2(vr2), .spr_upr(upr), .spr_cpucfgr(cpucfgr),
    .spr_dmmucfgr(dmmu), .spr_immucfgr(immu), .spr_dccfgr(dccfgr), .spr_iccfgr(iccfgr),
    .spr_dcfgr(dcfgr), .spr_pccfgr(pccfgr), .spr_fpcsr(fpcsr), .spr_avr(avr),
    .spr_bus_ack_o(ack3), .spr_bus_dat_o(dato3), .spr_bus_hit_o(hit3),
    .we_err_o(err3), .we_err_cnt_o(cnt3));

  mor1kx_cfgrs_spr_port #(.OPTION_RSP_DELAY(0), .OPTION_WE_ERR_EN(1'b0)) u_dn (
    .clk(clk), .rst(rst), .spr_bus_stb_i(stb), .spr_bus_we_i(we), .spr_bus_addr_i(addr),
    .spr_bus_dat_i(wdat), .spr_vr(vr), .spr_vr2(vr2), .spr_upr(upr), .spr_cpucfgr(cpucfgr),
    .spr_dmmucfgr(dmmu), .spr_immucfgr(immu), .spr_dccfgr(dccfgr), .spr_iccfgr(iccfgr),
    .spr_dcfgr(dcfgr), .spr_pccfgr(pccfgr), .spr_fpcsr(fpcsr), .spr_avr(avr),
    .spr_bus_ack_o(ackn), .spr_bus_dat_o(daton), .spr_bus_hit_o(hitn),
    .we_err_o(errn), .we_err_cnt_o(cntn));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with the DUTs idle; returns in the same phase.
  task automatic access(input logic [15:0] a, input logic w, input int hold);
    addr = a; we = w; wdat = 32'hA5A5A5A5; stb = 1'b1;
    lat0 = -1; lat3 = -1; acks0 = 0; acks3 = 0;
    dat0 = 'x; dat3 = 'x; h0 = 1'bx; h3 = 1'bx;
    for (int n = 0; n < 8 + hold; n++) begin
      @(negedge clk);
      if (ack0) begin
        acks0++;
        if (lat0 < 0) begin lat0 = n; dat0 = dato0; h0 = hit0; end
      end else if (dato0 !== 32'd0) begin
        chk("dat0_idle_zero", dato0, 32'd0);
      end
      if (ack3) begin
        acks3++;
        if (lat3 < 0) begin lat3 = n; dat3 = dato3; h3 = hit3; end
      end
      if (mutate && n == 2) begin vr = 32'hDEADBEEF; fpcsr = 32'hFFFF0000; end
    end
    @(posedge clk); #1 stb = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [15:0] ta[15];
  logic [31:0] td[15];
  logic        th[15];
  int          tot_acks;

  initial begin
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; wdat = '0; mutate = 1'b0;
    vr = 32'h10000040; vr2 = 32'h12345678; upr = 32'h00000619; cpucfgr = 32'h00000020;
    dmmu = 32'h11; immu = 32'h22; dccfgr = 32'h33; iccfgr = 32'h44; dcfgr = 32'h55;
    pccfgr = 32'h66; fpcsr = 32'h0; avr = 32'h0A0B0C0D;
    ta[0]  = 16'h0000; td[0]  = 32'h10000040; th[0]  = 1;
    ta[1]  = 16'h0001; td[1]  = 32'h00000619; th[1]  = 1;
    ta[2]  = 16'h0002; td[2]  = 32'h00000020; th[2]  = 1;
    ta[3]  = 16'h0003; td[3]  = 32'h11;       th[3]  = 1;
    ta[4]  = 16'h0004; td[4]  = 32'h22;       th[4]  = 1;
    ta[5]  = 16'h0005; td[5]  = 32'h33;       th[5]  = 1;
    ta[6]  = 16'h0006; td[6]  = 32'h44;       th[6]  = 1;
    ta[7]  = 16'h0007; td[7]  = 32'h55;       th[7]  = 1;
    ta[8]  = 16'h0008; td[8]  = 32'h66;       th[8]  = 1;
    ta[9]  = 16'h0009; td[9]  = 32'h12345678; th[9]  = 1;
    ta[10] = 16'h000A; td[10] = 32'h0A0B0C0D; th[10] = 1;
    ta[11] = 16'h0014; td[11] = 32'h0;        th[11] = 1;
    ta[12] = 16'h000B; td[12] = 32'h0;        th[12] = 0;
    ta[13] = 16'h0801; td[13] = 32'h0;        th[13] = 0;
    ta[14] = 16'h0015; td[14] = 32'h0;        th[14] = 0;

    #12;
    chk("rst_ack", {31'd0, ack0}, 32'd0);
    chk("rst_dat", dato0, 32'd0);
    chk("rst_hit", {31'd0, hit0}, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_cnt", {24'd0, cnt0}, 32'd0);
    chk("rst_ack3", {31'd0, ack3}, 32'd0);

    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      access(ta[i], 1'b0, 0);
      chk($sformatf("lat0_%h", ta[i]), 32'(lat0), 32'd2);
      chk($sformatf("lat3_%h", ta[i]), 32'(lat3), 32'd5);
      chk($sformatf("dat0_%h", ta[i]), dat0, td[i]);
      chk($sformatf("dat3_%h", ta[i]), dat3, td[i]);
      chk($sformatf("hit0_%h", ta[i]), {31'd0, h0}, {31'd0, th[i]});
      chk($sformatf("hit3_%h", ta[i]), {31'd0, h3}, {31'd0, th[i]});
    end
    chk("miss_err", {31'd0, err0}, 32'd0);
    chk("miss_cnt", {24'd0, cnt0}, 32'd0);

    mutate = 1'b1;
    access(16'h0014, 1'b0, 0);
    chk("snap_fpcsr", dat3, 32'h0);
    chk("snap_fpcsr_lat", 32'(lat3), 32'd5);
    fpcsr = 32'h0; vr = 32'h10000040;
    access(16'h0000, 1'b0, 0);
    chk("snap_vr", dat3, 32'h10000040);
    mutate = 1'b0; fpcsr = 32'h0; vr = 32'h10000040;

    access(16'h0002, 1'b0, 10);
    chk("hold_acks0", 32'(acks0), 32'd1);
    chk("hold_acks3", 32'(acks3), 32'd1);
    access(16'h0003, 1'b0, 0);
    chk("after_hold_lat", 32'(lat0), 32'd2);
    chk("after_hold_dat", dat0, 32'h11);

    access(16'h00FF, 1'b1, 0);
    chk("wmiss_lat", 32'(lat0), 32'd2);
    chk("wmiss_hit", {31'd0, h0}, 32'd0);
    chk("wmiss_err", {31'd0, err0}, 32'd0);
    chk("wmiss_cnt", {24'd0, cnt0}, 32'd0);

    access(16'h0002, 1'b1, 0);
    tot_acks = acks0;
    chk("w1_dat", dat0, 32'd0);
    chk("w1_hit", {31'd0, h0}, 32'd1);
    chk("w1_err", {31'd0, err0}, 32'd1);
    chk("w1_cnt", {24'd0, cnt0}, 32'd1);
    for (int i = 1; i < 260; i++) begin
      access(16'h0002, 1'b1, 0);
      tot_acks += acks0;
    end
    chk("w260_acks", 32'(tot_acks), 32'd260);
    chk("w260_err", {31'd0, err0}, 32'd1);
    chk("w260_cnt", {24'd0, cnt0}, 32'h000000FF);
    chk("w260_cnt3", {24'd0, cnt3}, 32'h000000FF);
    chk("dis_err", {31'd0, errn}, 32'd0);
    chk("dis_cnt", {24'd0, cntn}, 32'd0);
    access(16'h00FF, 1'b1, 0);
    chk("wmiss_sat_cnt", {24'd0, cnt0}, 32'h000000FF);

    addr = 16'h0001; we = 1'b0; stb = 1'b1;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("mid_rst_ack", {31'd0, ack0}, 32'd0);
    chk("mid_rst_dat", dato0, 32'd0);
    chk("mid_rst_err", {31'd0, err0}, 32'd0);
    chk("mid_rst_cnt", {24'd0, cnt0}, 32'd0);
    stb = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    acks0 = 0; acks3 = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ack0) acks0++;
      if (ack3) acks3++;
    end
    chk("mid_rst_noack0", 32'(acks0), 32'd0);
    chk("mid_rst_noack3", 32'(acks3), 32'd0);
    @(posedge clk); #1;
    access(16'h0009, 1'b0, 0);
    chk("post_rst_lat0", 32'(lat0), 32'd2);
    chk("post_rst_lat3", 32'(lat3), 32'd5);
    chk("post_rst_dat0", dat0, 32'h12345678);
    chk("post_rst_dat3", dat3, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
